mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
//   32-bit integer ALU for the MIPS datapath execute stage.
//   Performs AND/OR/ADD/SUB/SLT/NOR on operands A and B, selected by a 4-bit
//   control code from ALU control. Result and status flags are registered:
//   one clock, asynchronous active-high reset.
// PARAMETERS
//   WIDTH   32   operand/result width; flag rules below refer to bit WIDTH-1
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active high
//   A         in   32     operand A (two's complement for signed ops)
//   B         in   32     operand B
//   control   in   4      operation select (see BEHAVIOUR)
//   S         out  32     registered result
//   carryout  out  1      registered carry out of MSB adder stage
//   zero      out  1      registered flag, 1 when S == 0
//   overflow  out  1      registered signed-overflow flag
// BEHAVIOUR
//   Reset: while rst=1, asynchronously S=0, carryout=0, overflow=0, zero=1
//     (consistent with S=0). First capture is on the first rising clk after
//     rst deasserts.
//   Latency: one cycle. Outputs reflect inputs sampled at the previous
//     rising edge; no handshake; a new operation is accepted every cycle.
//   Datapath: compute combinationally from A/B/control, register all four
//     outputs together.
//   Opcodes:
//     0000 AND  S=A&B;  carryout=0, overflow=0
//     0001 OR   S=A|B;  carryout=0, overflow=0
//     0010 ADD  {c,S}=A+B;  carryout=c
//               overflow=(A[31]==B[31]) && (S[31]!=A[31])
//     0110 SUB  {c,S}=A+~B+1;  carryout=c (1 = no borrow)
//               overflow=(A[31]!=B[31]) && (S[31]!=A[31])
//     0111 SLT  S={31'b0, lt}; lt = signed A<B = diff[31]^ovf_sub
//               (correct even when subtraction overflows)
//               carryout=0, overflow=0
//     1100 NOR  S=~(A|B);  carryout=0, overflow=0
//     other     S=0, carryout=0, overflow=0 (zero therefore 1)
//   zero = ~|S, evaluated on the result being registered.
//   Arithmetic is modulo 2^32; wrap-around never traps, only flags.
//   Mid-operation reset: the result in flight is discarded and outputs go
//     to their reset values immediately.
// TESTING
//   Apply stimulus, clock once, then check outputs.
//   1. rst pulse -> S=0, zero=1, carryout=0, overflow=0 (no clock needed).
//   2. AND A=00000001 B=00000003 -> S=00000001, zero=0.
//      AND A=f0000001 B=f0000003 -> S=f0000001.
//   3. SUB A=00000001 B=00000003 -> S=fffffffe, carryout=0, overflow=0.
//      SUB A=80000000 B=00111111 -> S=7feeeeef, overflow=1, carryout=1.
//   4. ADD A=7fffffff B=00111111 -> S=80111110, overflow=1, carryout=0.
//      ADD A=ffffffff B=00000001 -> S=0, zero=1, carryout=1, overflow=0.
//   5. SLT A=f0000001 B=f0000003 -> S=00000001.
//      SLT A=80000000 B=00000001 -> S=1 (overflow case).
//      SLT A=5 B=5 -> S=0, zero=1.
//   6. OR/NOR with A=0 B=0 -> S=0 / ffffffff. Undefined control 1111 -> S=0,
//      zero=1. Back-to-back ops each land exactly one cycle later.

Source files
------------

// File: rtl/mips_alu.sv
// Execute-stage integer ALU for the MIPS datapath.
// Result and status flags are registered with one cycle of latency.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] S,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt;
  logic [WIDTH-1:0] s_nxt;
  logic             c_nxt;
  logic             v_nxt;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} + {1'b0, ~B}
              + {{WIDTH{1'b0}}, 1'b1};

  assign ovf_add = (A[WIDTH-1] == B[WIDTH-1])
                && (sum[WIDTH-1] != A[WIDTH-1]);
  assign ovf_sub = (A[WIDTH-1] != B[WIDTH-1])
                && (diff[WIDTH-1] != A[WIDTH-1]);

  // Sign of the difference corrected by overflow gives a true signed compare.
  assign lt = diff[WIDTH-1] ^ ovf_sub;

  always_comb begin
    s_nxt = '0;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (control)
      OP_AND: s_nxt = A & B;
      OP_OR:  s_nxt = A | B;
      OP_ADD: begin
        s_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = ovf_add;
      end
      OP_SUB: begin
        s_nxt = diff[WIDTH-1:0];
        c_nxt = diff[WIDTH];
        v_nxt = ovf_sub;
      end
      OP_SLT: s_nxt = {{(WIDTH-1){1'b0}}, lt};
      OP_NOR: s_nxt = ~(A | B);
      default: s_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S        <= '0;
      carryout <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      S        <= s_nxt;
      carryout <= c_nxt;
      zero     <= ~|s_nxt;
      overflow <= v_nxt;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: randomized and directed operations
// checked against an arithmetic reference model.
module tb_mips_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  control;
  logic [31:0] S;
  logic        carryout;
  logic        zero;
  logic        overflow;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        z;
    logic        v;
    string       name;
  } exp_t;

  exp_t q[$];

  mips_alu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .control(control),
    .S(S),
    .carryout(carryout),
    .zero(zero),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op,
    input string       nm
  );
    exp_t e;
    longint ua, ub, sa, sb, r;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.s = 32'd0;
    e.c = 1'b0;
    e.v = 1'b0;
    e.name = nm;
    case (op)
      4'b0000: e.s = a & b;
      4'b0001: e.s = a | b;
      4'b0010: begin
        e.s = a + b;
        e.c = (ua + ub) > 64'sd4294967295;
        r = sa + sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0110: begin
        e.s = a - b;
        e.c = (ua >= ub);
        r = sa - sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0111: e.s = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.s = ~(a | b);
      default: e.s = 32'd0;
    endcase
    e.z = (e.s == 32'd0);
    return e;
  endfunction

  task automatic issue(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op,
    input string       nm
  );
    @(negedge clk);
    A = a;
    B = b;
    control = op;
    q.push_back(model(a, b, op, nm));
  endtask

  task automatic check_rst(input string nm);
    tests++;
    if (S !== 32'd0 || zero !== 1'b1 ||
        carryout !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL %s: got S=%h c=%b z=%b v=%b, want S=0 c=0 z=1 v=0",
               nm, S, carryout, zero, overflow);
    end
  endtask

  // Monitor: each rising edge retires the oldest outstanding operation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0 && !rst) begin
        e = q.pop_front();
        tests++;
        if (S !== e.s || carryout !== e.c ||
            zero !== e.z || overflow !== e.v) begin
          fails++;
          $display("FAIL %s: got S=%h c=%b z=%b v=%b, want S=%h c=%b z=%b v=%b",
                   e.name, S, carryout, zero, overflow,
                   e.s, e.c, e.z, e.v);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: %0d results never retired, want 0",
               nm, q.size());
      q.delete();
    end
  endtask

  logic [3:0] ops [7];

  initial begin
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1100;
    ops[6] = 4'b1111;
    tests = 0;
    fails = 0;
    A = '0;
    B = '0;
    control = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_rst("reset_async");
    @(posedge clk);
    #1 check_rst("reset_held");
    @(negedge clk);
    rst = 1'b0;

    issue(32'h00000001, 32'h00000003, 4'b0000, "and_small");
    issue(32'hf0000001, 32'hf0000003, 4'b0000, "and_high");
    issue(32'h00000001, 32'h00000003, 4'b0110, "sub_borrow");
    issue(32'h80000000, 32'h00111111, 4'b0110, "sub_ovf");
    issue(32'h7fffffff, 32'h00111111, 4'b0010, "add_ovf");
    issue(32'hffffffff, 32'h00000001, 4'b0010, "add_wrap");
    issue(32'hf0000001, 32'hf0000003, 4'b0111, "slt_neg");
    issue(32'h80000000, 32'h00000001, 4'b0111, "slt_ovf");
    issue(32'h00000001, 32'h80000000, 4'b0111, "slt_ovf_rev");
    issue(32'h00000005, 32'h00000005, 4'b0111, "slt_eq");
    issue(32'h00000000, 32'h00000000, 4'b0001, "or_zero");
    issue(32'h00000000, 32'h00000000, 4'b1100, "nor_zero");
    issue(32'h12345678, 32'h9abcdef0, 4'b1111, "undef_op");
    issue(32'h00000007, 32'h00000007, 4'b0110, "sub_equal");
    issue(32'h80000000, 32'h80000000, 4'b0010, "add_minmin");
    drain("directed");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 8 == 0) ? a : 32'($urandom);
      if (i % 16 == 1) a = 32'h80000000;
      issue(a, b, ops[$urandom_range(6, 0)], "random");
    end
    drain("random");

    // Reset arriving with an operation already set up must discard it.
    @(negedge clk);
    A = 32'h00000001;
    B = 32'h00000002;
    control = 4'b0010;
    #2 rst = 1'b1;
    #1 check_rst("mid_reset_async");
    @(posedge clk);
    #1 check_rst("mid_reset_edge");
    @(negedge clk);
    rst = 1'b0;
    issue(32'h00000001, 32'h00000002, 4'b0010, "post_reset_add");
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
